// File: rtl/dcm_lock_monitor_if.sv
// Signal bundle between a DCM and its lock monitor.
// master = monitor side (drives DCM reset and status flags), slave = DCM side.
interface dcm_lock_monitor_if;
  logic       dcm_locked;
  logic [7:0] dcm_status;
  logic       dcm_rst;
  logic       clk_ready;
  logic       lock_lost;
  logic [7:0] relock_count;
  logic       fail;

  modport master (
    input  dcm_locked, dcm_status,
    output dcm_rst, clk_ready, lock_lost, relock_count, fail
  );

  modport slave (
    output dcm_locked, dcm_status,
    input  dcm_rst, clk_ready, lock_lost, relock_count, fail
  );
endinterface

// File: rtl/dcm_lock_monitor.sv
// DCM reset sequencer and lock supervisor: pulses DCM RST, filters LOCKED, gates clk_ready.
// Optional macro DCM_STATUS_CHECK_EN: treat STATUS[1]/STATUS[2] (clock stopped) as lock loss in RUN.
module dcm_lock_monitor #(
  parameter int RST_PULSE_LEN = 3,
  parameter int LOCK_FILTER   = 16,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int RETRY_MAX     = 15
) (
  input  logic               clkin,
  input  logic               rst,
  dcm_lock_monitor_if.master bus
);
  localparam int CNT_MAX = (RST_PULSE_LEN > LOCK_FILTER) ? RST_PULSE_LEN : LOCK_FILTER;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TMR_W   = $clog2(LOCK_TIMEOUT + 1);
  localparam int RETRY_W = $clog2(RETRY_MAX + 2);

  localparam logic [CNT_W-1:0]   PULSE_LAST  = CNT_W'(RST_PULSE_LEN - 1);
  // The WAIT_LOCK->SETTLE sample is the first of the LOCK_FILTER locked samples.
  localparam logic [CNT_W-1:0]   FILTER_LAST = CNT_W'(LOCK_FILTER - 2);
  localparam logic [TMR_W-1:0]   TIMER_LAST  = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(RETRY_MAX);

  typedef enum logic [2:0] {
    S_RESET_PULSE,
    S_WAIT_LOCK,
    S_SETTLE,
    S_RUN,
    S_FAIL
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               lock_lost_q, lock_lost_d;
  logic [7:0]         relock_q, relock_d;
  logic               dcm_rst_q, clk_ready_q, fail_q;

  // ---- stage p0/p1: LOCKED crosses into the clkin domain
  logic locked_p0, locked_p1;
  logic locked_s;
  always_ff @(posedge clkin) begin
    locked_p0 <= bus.dcm_locked;
    locked_p1 <= locked_p0;
  end
  assign locked_s = locked_p1;

  logic status_loss;
  logic unused_status;
`ifdef DCM_STATUS_CHECK_EN
  logic [1:0] stopped_p0, stopped_p1;
  always_ff @(posedge clkin) begin
    stopped_p0 <= bus.dcm_status[2:1];
    stopped_p1 <= stopped_p0;
  end
  assign status_loss   = |stopped_p1;
  assign unused_status = ^{bus.dcm_status[7:3], bus.dcm_status[0]};
`else
  assign status_loss   = 1'b0;
  assign unused_status = ^bus.dcm_status;
`endif

  // ---- next-state and counter logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timer_d     = timer_q;
    retry_d     = retry_q;
    lock_lost_d = lock_lost_q;
    relock_d    = relock_q;

    case (state_q)
      S_RESET_PULSE: begin
        cnt_d   = cnt_q + 1'b1;
        timer_d = '0;
        if (cnt_q == PULSE_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (timer_q != TIMER_LAST) timer_d = timer_q + 1'b1;
        if (locked_s) begin
          state_d = S_SETTLE;
        end else if (timer_q == TIMER_LAST) begin
          retry_d = retry_q + 1'b1;
          state_d = (retry_q == RETRY_LIMIT) ? S_FAIL : S_RESET_PULSE;
        end
      end
      S_SETTLE: begin
        // Timer deliberately keeps running across WAIT_LOCK/SETTLE bounces.
        if (timer_q != TIMER_LAST) timer_d = timer_q + 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (!locked_s)                state_d = S_WAIT_LOCK;
        else if (cnt_q == FILTER_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        if (!locked_s || status_loss) begin
          state_d     = S_RESET_PULSE;
          lock_lost_d = 1'b1;
          relock_d    = sat_inc8(relock_q);
        end
      end
      S_FAIL: begin
        state_d = S_FAIL;
      end
      default: begin
        state_d = S_RESET_PULSE;
      end
    endcase

    if (state_d != state_q) cnt_d = '0;
    if (state_d == S_RUN && state_q != S_RUN) retry_d = '0;
  end

  // ---- registered state and outputs
  always_ff @(posedge clkin) begin
    if (rst) begin
      state_q     <= S_RESET_PULSE;
      cnt_q       <= '0;
      timer_q     <= '0;
      retry_q     <= '0;
      lock_lost_q <= 1'b0;
      relock_q    <= 8'd0;
      dcm_rst_q   <= 1'b1;
      clk_ready_q <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      lock_lost_q <= lock_lost_d;
      relock_q    <= relock_d;
      dcm_rst_q   <= (state_d == S_RESET_PULSE);
      clk_ready_q <= (state_d == S_RUN);
      fail_q      <= (state_d == S_FAIL);
    end
  end

  assign bus.dcm_rst      = dcm_rst_q;
  assign bus.clk_ready    = clk_ready_q;
  assign bus.lock_lost    = lock_lost_q;
  assign bus.relock_count = relock_q;
  assign bus.fail         = fail_q;
endmodule
